// File: rtl/led_defs.sv
// led_defs: shared LED matrix constants, state encoding and pixel/address types
package led_defs;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int PIX_W = 12;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {IDLE, STREAM, FILL} state_t;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/led_addr_map.sv
// led_addr_map: raster index to RAM address; SERPENTINE_EN reverses odd rows for zig-zag panels
module led_addr_map
  import led_defs::*;
(
  input  addr_t idx,
  output addr_t addr
);
`ifdef SERPENTINE_EN
  addr_t row, col;
  assign row = addr_t'(idx / COLS);
  assign col = addr_t'(idx % COLS);
  assign addr = row[0] ? addr_t'(row * COLS + (COLS - 1) - col) : idx;
`else
  assign addr = idx;
`endif
endmodule

// File: rtl/led_frame_writer.sv
// led_frame_writer: turns a pixel stream or fill command into registered LED frame-RAM writes
module led_frame_writer
  import led_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_sof,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              fill_req,
  input  logic [PIX_W-1:0]  fill_colour,
  output logic [PIX_W-1:0]  ramIn,
  output logic [ADDR_W-1:0] wrAdd,
  output logic              we,
  output logic              frame_done,
  output logic              err_sync,
  output logic [7:0]        frame_cnt
);
  localparam addr_t LAST = addr_t'(ROWS * COLS - 1);
  state_t state, state_n;
  addr_t idx, idx_n, wr_idx, map_addr;
  pixel_t fill_pix, wr_data;
  logic acc, last, wr, done, err;
  assign pix_ready = (state == STREAM) || (state == IDLE && !fill_req);
  assign acc = pix_valid && pix_ready;
  assign last = idx == LAST;
  led_addr_map u_map (.idx(wr_idx), .addr(map_addr));
  always_comb begin
    state_n = state;
    idx_n = idx;
    wr = 1'b0;
    wr_idx = idx;
    wr_data = pix_data;
    done = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req) begin
          state_n = FILL;
          idx_n = '0;
        end else if (acc) begin
          wr = pix_sof;
          err = !pix_sof;
          wr_idx = '0;
          idx_n = pix_sof ? addr_t'(1) : idx;
          state_n = pix_sof ? STREAM : IDLE;
        end
      end
      STREAM: begin
        if (acc && pix_sof) begin
          wr = 1'b1;
          err = 1'b1;
          wr_idx = '0;
          idx_n = addr_t'(1);
        end else if (acc) begin
          wr = 1'b1;
          done = last;
          idx_n = last ? '0 : idx + addr_t'(1);
          state_n = last ? IDLE : STREAM;
        end
      end
      FILL: begin
        wr = 1'b1;
        wr_data = fill_pix;
        done = last;
        idx_n = last ? '0 : idx + addr_t'(1);
        state_n = last ? IDLE : FILL;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      we <= 1'b0;
      wrAdd <= '0;
      ramIn <= '0;
      frame_done <= 1'b0;
      err_sync <= 1'b0;
      frame_cnt <= '0;
      fill_pix <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      we <= wr;
      if (wr) begin
        wrAdd <= map_addr;
        ramIn <= wr_data;
      end
      frame_done <= done;
      err_sync <= err;
      frame_cnt <= frame_cnt + 8'(done);
      if (state == IDLE && fill_req) fill_pix <= fill_colour;
    end
  end
endmodule

// File: tb/tb_led_frame_writer.sv
// tb_led_frame_writer: directed bench for led_frame_writer; expected writes queued and matched in order
module tb_led_frame_writer;
  logic clk, rst, pix_sof, pix_valid, pix_ready, fill_req, we, frame_done, err_sync;
  logic [11:0] pix_data, fill_colour, ramIn;
  logic [7:0] wrAdd, frame_cnt;
  int n_chk, n_fail, wcnt, bad, done_n, done_at, err_n;
  logic [19:0] exp_q[$];
  logic [7:0] wlog[4096];

  led_frame_writer dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .fill_req(fill_req), .fill_colour(fill_colour), .ramIn(ramIn),
    .wrAdd(wrAdd), .we(we), .frame_done(frame_done), .err_sync(err_sync), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] map(input int i);
`ifdef SERPENTINE_EN
    if (((i / 16) % 2) == 1) return 8'(i ^ 15);
`endif
    return 8'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] d, input logic s);
    pix_data = d;
    pix_sof = s;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic expect_wr(input int i, input logic [11:0] d);
    exp_q.push_back({map(i), d});
  endtask

  task automatic frame(input logic [11:0] base, input bit gaps);
    for (int i = 0; i < 256; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      expect_wr(i, 12'(base + 12'(i)));
      send(12'(base + 12'(i)), i == 0);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wlog[wcnt] = wrAdd;
      wcnt++;
      if (exp_q.size() == 0) bad++;
      else if ({wrAdd, ramIn} !== exp_q.pop_front()) bad++;
    end
    if (frame_done === 1'b1) begin
      done_n++;
      done_at = wcnt;
      if (we !== 1'b1) bad++;
    end
    if (err_sync === 1'b1) err_n++;
  end

  initial begin
    rst = 1'b1;
    pix_data = '0;
    pix_sof = 1'b0;
    pix_valid = 1'b0;
    fill_req = 1'b0;
    fill_colour = '0;
    idle(3);
    rst = 1'b0;
    check("rst we", we, 0);
    check("rst wrAdd", wrAdd, 0);
    check("rst ramIn", ramIn, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst pix_ready", pix_ready, 1);

    frame(12'h000, 1'b0);
    idle(3);
    check("t1 writes", wcnt, 256);
    check("t1 order", bad, 0);
    check("t1 done count", done_n, 1);
    check("t1 done at last", done_at, 256);
    check("t1 frame_cnt", frame_cnt, 1);
`ifdef SERPENTINE_EN
    check("t1 idx16", wlog[16], 31);
    check("t1 idx31", wlog[31], 16);
`else
    check("t1 idx16", wlog[16], 16);
    check("t1 idx31", wlog[31], 31);
`endif
    check("t1 idx32", wlog[32], 32);

    send(12'hABC, 1'b0);
    idle(2);
    check("t2 err pulse", err_n, 1);
    check("t2 no write", wcnt, 256);
    expect_wr(0, 12'h000);
    send(12'h000, 1'b1);
    idle(2);
    check("t2 sof write", wcnt, 257);
    check("t2 sof addr", wlog[256], 0);

    for (int i = 1; i < 100; i++) begin
      expect_wr(i, 12'(i));
      send(12'(i), 1'b0);
    end
    expect_wr(0, 12'h123);
    send(12'h123, 1'b1);
    idle(2);
    check("t3 err pulse", err_n, 2);
    check("t3 restart data", ramIn, 12'h123);
    check("t3 restart addr", wrAdd, 0);
    check("t3 no early done", done_n, 1);
    for (int i = 1; i < 256; i++) begin
      expect_wr(i, 12'(i));
      send(12'(i), 1'b0);
    end
    idle(3);
    check("t3 done count", done_n, 2);
    check("t3 frame_cnt", frame_cnt, 2);
    check("t3 order", bad, 0);

    fill_colour = 12'hF00;
    fill_req = 1'b1;
    pix_data = 12'h555;
    pix_sof = 1'b1;
    pix_valid = 1'b1;
    #1;
    check("t4 ready low on fill", pix_ready, 0);
    for (int i = 0; i < 256; i++) expect_wr(i, 12'hF00);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    fill_req = 1'b0;
    fill_colour = 12'h0FF;
    check("t4 ready low in fill", pix_ready, 0);
    idle(260);
    check("t4 done count", done_n, 3);
    check("t4 frame_cnt", frame_cnt, 3);
    check("t4 ready back", pix_ready, 1);
    check("t4 all written", exp_q.size(), 0);
    check("t4 order", bad, 0);
    check("t4 no err", err_n, 2);

    for (int i = 0; i < 50; i++) begin
      expect_wr(i, 12'h800 + 12'(i));
      send(12'h800 + 12'(i), i == 0);
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("t5 frame_cnt", frame_cnt, 0);
    check("t5 we", we, 0);
    idle(5);
    check("t5 no done", done_n, 3);
    check("t5 partial written", exp_q.size(), 0);
    check("t5 no extra we", bad, 0);
    frame(12'h300, 1'b0);
    idle(3);
    check("t5 done count", done_n, 4);
    check("t5 frame_cnt", frame_cnt, 1);

    frame(12'h400, 1'b1);
    idle(3);
    check("t6 done count", done_n, 5);
    check("t6 frame_cnt", frame_cnt, 2);
    check("t6 all written", exp_q.size(), 0);
    check("t6 order", bad, 0);
    check("t6 no err", err_n, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
